// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets two byte requesters share one UART transmitter.
// It waits for the transmitter to start and finish each frame, and times out if it never starts.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arb_EN,
  input  logic       req_A,
  input  logic       req_B,
  input  logic [7:0] data_A,
  input  logic [7:0] data_B,
  output logic       gnt_A,
  output logic       gnt_B,
  input  logic       Tx_BUSY,
  output logic       Tx_EN,
  output logic       Tx_WR,
  output logic [7:0] Tx_DATA,
  output logic       last_src,
  output logic       tx_timeout,
  output logic       arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_FLUSH
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_tx_wr;
  logic [7:0] r_tx_data;
  logic       r_last_src;
  logic       r_timeout;
  logic       r_busy;
  logic       r_tx_en;
  logic       w_grant;
  logic       w_win_b;
  logic       w_timeout_hit;

  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_timeout_hit = 1'b0;
    // On a tie the source that was not served last wins.
    w_win_b       = (req_A && req_B) ? ~r_last_src : req_B;
    case (r_state)
      S_IDLE: begin
        if (arb_EN && !Tx_BUSY && (req_A || req_B)) begin
          w_grant      = 1'b1;
          w_state_next = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (Tx_BUSY) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_cnt == TIMEOUT_C) begin
          w_timeout_hit = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!Tx_BUSY) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'h00;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_last_src <= 1'b1;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_en    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tx_wr   <= w_grant;
      r_gnt_a   <= w_grant & ~w_win_b;
      r_gnt_b   <= w_grant & w_win_b;
      r_timeout <= w_timeout_hit;
      // Built from the next state so it tracks the state register exactly.
      r_busy    <= (w_state_next != S_IDLE);
      r_tx_en   <= arb_EN || (r_state != S_IDLE);
      if (w_grant) begin
        r_tx_data  <= w_win_b ? data_B : data_A;
        r_last_src <= w_win_b;
        r_cnt      <= 8'h00;
      end else if (r_state == S_WAIT_START && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign gnt_A      = r_gnt_a;
  assign gnt_B      = r_gnt_b;
  assign Tx_WR      = r_tx_wr;
  assign Tx_DATA    = r_tx_data;
  assign last_src   = r_last_src;
  assign tx_timeout = r_timeout;
  assign arb_busy   = r_busy;
  assign Tx_EN      = r_tx_en;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a grant scoreboard plus per-scenario tasks,
// with a simple transmitter model that stays busy for 10 cycles per written byte.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       reset;
  logic       arb_EN;
  logic       req_A;
  logic       req_B;
  logic [7:0] data_A;
  logic [7:0] data_B;
  logic       gnt_A;
  logic       gnt_B;
  logic       Tx_BUSY;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       last_src;
  logic       tx_timeout;
  logic       arb_busy;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic model_en = 1'b1;
  logic man_busy = 1'b0;
  int   model_cnt = 0;

  uart_tx_arbiter #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .arb_EN    (arb_EN),
    .req_A     (req_A),
    .req_B     (req_B),
    .data_A    (data_A),
    .data_B    (data_B),
    .gnt_A     (gnt_A),
    .gnt_B     (gnt_B),
    .Tx_BUSY   (Tx_BUSY),
    .Tx_EN     (Tx_EN),
    .Tx_WR     (Tx_WR),
    .Tx_DATA   (Tx_DATA),
    .last_src  (last_src),
    .tx_timeout(tx_timeout),
    .arb_busy  (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: goes busy as soon as it sees the write strobe.
  always @(negedge clk) begin
    if (Tx_WR === 1'b1) model_cnt = 10;
    else if (model_cnt > 0) model_cnt = model_cnt - 1;
  end
  assign Tx_BUSY = model_en ? (model_cnt != 0) : man_busy;

  // Scoreboard: every grant must match the oldest expected (source, byte).
  always @(negedge clk) begin
    if (gnt_A === 1'b1 || gnt_B === 1'b1) begin
      n_checks++;
      if (gnt_A && gnt_B) begin
        n_fail++;
        $display("FAIL gnt_exclusive: gnt_A=%b gnt_B=%b required one-hot", gnt_A, gnt_B);
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_gnt: gnt_A=%b gnt_B=%b Tx_DATA=%02h required no grant", gnt_A, gnt_B, Tx_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({gnt_B, Tx_DATA, Tx_WR, last_src} !== {mon_e.src, mon_e.data, 1'b1, mon_e.src}) begin
          n_fail++;
          $display("FAIL sb_grant: src=%b data=%02h wr=%b last=%b required src=%b data=%02h wr=1 last=%b",
                   gnt_B, Tx_DATA, Tx_WR, last_src, mon_e.src, mon_e.data, mon_e.src);
        end else begin
          $display("grant src=%s data=%02h", gnt_B ? "B" : "A", Tx_DATA);
        end
      end
    end else if (Tx_WR === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_without_gnt: Tx_WR=1 gnt_A=0 gnt_B=0 required no write");
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({Tx_WR, gnt_A, gnt_B, tx_timeout, arb_busy, Tx_EN} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: {wr,gA,gB,to,busy,en}=%b required 000000",
               {Tx_WR, gnt_A, gnt_B, tx_timeout, arb_busy, Tx_EN});
    end
    n_checks++;
    if (Tx_DATA !== 8'h00 || last_src !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_data: Tx_DATA=%02h last_src=%b required 00 / 1", Tx_DATA, last_src);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    reset = 1'b0; arb_EN = 1'b1; req_A = 1'b1; data_A = 8'hA5;
    exp_q.push_back('{src: 1'b0, data: 8'hA5});
    @(negedge clk);
    n_checks++;
    if ({Tx_WR, gnt_A, gnt_B, Tx_DATA, last_src, arb_busy, Tx_EN} !== {3'b110, 8'hA5, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: wr=%b gA=%b gB=%b data=%02h last=%b busy=%b en=%b required 1 1 0 a5 0 1 1",
               Tx_WR, gnt_A, gnt_B, Tx_DATA, last_src, arb_busy, Tx_EN);
    end
    req_A = 1'b0;
    @(negedge clk);
    n_checks++;
    if (Tx_WR !== 1'b0 || gnt_A !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: wr=%b gA=%b required 0 0", Tx_WR, gnt_A);
    end
    for (int i = 0; i < 50; i++) begin
      if (arb_busy === 1'b0) break;
      @(negedge clk);
    end
    n_checks++;
    if (arb_busy !== 1'b0 || Tx_DATA !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b data=%02h required 0 a5", arb_busy, Tx_DATA);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int prev = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('{src: 1'b0, data: 8'h11});
    exp_q.push_back('{src: 1'b1, data: 8'h22});
    exp_q.push_back('{src: 1'b0, data: 8'h11});
    exp_q.push_back('{src: 1'b1, data: 8'h22});
    req_A = 1'b1; req_B = 1'b1; data_A = 8'h11; data_B = 8'h22;
    for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
      @(negedge clk);
      if (gnt_A === 1'b1 || gnt_B === 1'b1) begin
        if (n > 0) begin
          n_checks++;
          if (cyc - prev != 13) begin
            n_fail++;
            $display("FAIL rr_spacing: grant gap=%0d cycles required 13", cyc - prev);
          end
        end
        prev = cyc;
        n++;
      end
    end
    req_A = 1'b0; req_B = 1'b0;
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL rr_count: grants=%0d required 4", n);
    end
    for (int i = 0; i < 50; i++) begin
      if (arb_busy === 1'b0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int hits = 0;
    int first = 0;
    model_en = 1'b0; man_busy = 1'b0;
    req_B = 1'b1; data_B = 8'h3C;
    exp_q.push_back('{src: 1'b1, data: 8'h3C});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Tx_WR === 1'b1) break;
    end
    req_B = 1'b0;
    n_checks++;
    if (Tx_WR !== 1'b1) begin
      n_fail++;
      $display("FAIL to_wait_wr: Tx_WR=%b required 1 within bound", Tx_WR);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (tx_timeout === 1'b1) begin
        hits++;
        if (first == 0) first = k;
        n_checks++;
        if (arb_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL to_idle: arb_busy=%b at timeout required 0", arb_busy);
        end
      end
    end
    n_checks++;
    if (first != 16 || hits != 1) begin
      n_fail++;
      $display("FAIL to_latency: first pulse at %0d (pulses=%0d) required 16 (1)", first, hits);
    end
    $display("timeout pulse at +%0d", first);
  endtask

  task automatic test_enable_drop();
    int gcount = 0;
    logic found = 1'b0;
    model_en = 1'b1;
    arb_EN = 1'b1; req_A = 1'b1; data_A = 8'h5A;
    exp_q.push_back('{src: 1'b0, data: 8'h5A});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_A === 1'b1) break;
    end
    repeat (2) @(negedge clk);
    arb_EN = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arb_busy === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || Tx_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL en_at_idle: reached=%b Tx_EN=%b required 1 1", found, Tx_EN);
    end
    @(negedge clk);
    n_checks++;
    if (Tx_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL en_fall: Tx_EN=%b required 0", Tx_EN);
    end
    repeat (30) begin
      @(negedge clk);
      if (gnt_A === 1'b1) gcount++;
    end
    req_A = 1'b0;
    n_checks++;
    if (gcount != 0 || Tx_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL en_no_grant: grants=%0d Tx_EN=%b required 0 0", gcount, Tx_EN);
    end
  endtask

  task automatic test_reset_mid_frame();
    arb_EN = 1'b1; req_A = 1'b1; data_A = 8'h77;
    exp_q.push_back('{src: 1'b0, data: 8'h77});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt_A === 1'b1) break;
    end
    req_A = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (arb_busy !== 1'b1 || last_src !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b last=%b required 1 0", arb_busy, last_src);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({Tx_WR, gnt_A, gnt_B, tx_timeout, arb_busy, Tx_EN, Tx_DATA, last_src} !== {6'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid: wr=%b gA=%b gB=%b to=%b busy=%b en=%b data=%02h last=%b required 0 0 0 0 0 0 00 1",
               Tx_WR, gnt_A, gnt_B, tx_timeout, arb_busy, Tx_EN, Tx_DATA, last_src);
    end
    reset = 1'b0; arb_EN = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: busy=%b required 0", arb_busy);
    end
  endtask

  task automatic test_external_busy();
    int gcount = 0;
    model_en = 1'b0; man_busy = 1'b1;
    arb_EN = 1'b1; req_A = 1'b1; data_A = 8'hC3;
    exp_q.push_back('{src: 1'b0, data: 8'hC3});
    repeat (20) begin
      @(negedge clk);
      if (gnt_A === 1'b1) gcount++;
    end
    n_checks++;
    if (gcount != 0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_hold: grants=%0d busy=%b required 0 0", gcount, arb_busy);
    end
    man_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_A !== 1'b1 || Tx_DATA !== 8'hC3) begin
      n_fail++;
      $display("FAIL ext_release: gA=%b data=%02h required 1 c3", gnt_A, Tx_DATA);
    end
    req_A = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arb_busy === 1'b0) break;
    end
    n_checks++;
    if (arb_busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ext_end: busy=%b pending=%0d required 0 0", arb_busy, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; arb_EN = 1'b0; req_A = 1'b0; req_B = 1'b0;
    data_A = 8'h00; data_B = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_enable_drop();
    test_reset_mid_frame();
    test_external_busy();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
